// File: rtl/aes_stream_ctrl.sv
// rtl/aes_stream_ctrl.sv - streaming front/back-end for the pipelined AES_TOP core
//
// Issues plaintext/key pairs to a free-running, unstallable AES core. Each
// block is tracked through the fixed core latency with a valid shift register,
// and every ciphertext is captured into a result FIFO. Credits (inflight +
// queued) never exceed FIFO_DEPTH, so no core result can be lost under
// output backpressure.
//
// Optional feature macro: AES_STREAM_CNT_EN adds blk_in_cnt / blk_out_cnt.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   s_valid/s_ready        input handshake
//   s_data, s_key          plaintext and key (128 bits each)
//   core_datain, core_key  registered operands to the core (0 when idle)
//   core_finalout          ciphertext from the core
//   m_valid/m_ready        output handshake
//   m_data                 ciphertext at the FIFO head
//   busy                   blocks in flight or queued
//   blk_in_cnt             (AES_STREAM_CNT_EN) accepted block count
//   blk_out_cnt            (AES_STREAM_CNT_EN) delivered block count

module aes_stream_ctrl #(
  parameter int CORE_LAT   = 20,
  parameter int FIFO_DEPTH = 32,
  parameter int AW         = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic [127:0] s_key,
  output logic [127:0] core_datain,
  output logic [127:0] core_key,
  input  logic [127:0] core_finalout,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         busy
`ifdef AES_STREAM_CNT_EN
  ,
  output logic [31:0]  blk_in_cnt,
  output logic [31:0]  blk_out_cnt
`endif
);

  localparam int CW = AW + 1;

  logic [CORE_LAT+1:0] vld_sr;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       fcnt;
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [127:0]        mem [FIFO_DEPTH];

  logic                accept;
  logic                res_vld;
  logic                fifo_full;
  logic                wr_en;
  logic                pop;
  logic [CW:0]         occ;

  assign accept    = s_valid & s_ready;
  // Top bit of the tracker: core_finalout holds a real result this cycle.
  assign res_vld   = vld_sr[CORE_LAT+1];
  assign fifo_full = (fcnt == CW'(FIFO_DEPTH));
  assign wr_en     = res_vld & ~fifo_full;
  assign pop       = m_valid & m_ready;

  // Credit check counts blocks still inside the core as already occupying
  // FIFO space; this is what makes the unstallable core safe.
  assign occ       = {1'b0, inflight} + {1'b0, fcnt};
  assign s_ready   = (occ < (CW + 1)'(FIFO_DEPTH));
  assign m_valid   = (fcnt != '0);
  assign m_data    = mem[rptr];
  assign busy      = (inflight != '0) || (fcnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_datain <= '0;
      core_key    <= '0;
    end else if (accept) begin
      core_datain <= s_data;
      core_key    <= s_key;
    end else begin
      core_datain <= '0;
      core_key    <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[CORE_LAT:0], accept};
    end
  end

  // A result leaving the core releases its inflight credit even in the
  // (never expected) case that the full FIFO drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({accept, res_vld})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Result storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= core_finalout;
    end
  end

`ifdef AES_STREAM_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_in_cnt  <= '0;
      blk_out_cnt <= '0;
    end else begin
      if (accept) begin
        blk_in_cnt <= blk_in_cnt + 32'd1;
      end
      if (pop) begin
        blk_out_cnt <= blk_out_cnt + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_result_drop: assert property (@(posedge clk) disable iff (!rst_n)
    !(res_vld && fifo_full));
`endif

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb/tb_aes_stream_ctrl.sv - self-checking bench for aes_stream_ctrl with a behavioural AES core

module tb_aes_stream_ctrl;

  localparam int CORE_LAT = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic [127:0] s_key;
  logic [127:0] core_datain;
  logic [127:0] core_key;
  logic [127:0] core_finalout;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         busy;
`ifdef AES_STREAM_CNT_EN
  logic [31:0]  blk_in_cnt;
  logic [31:0]  blk_out_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int pop_cnt  = 0;
  logic [127:0] drv_exp;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  aes_stream_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_key         (s_key),
    .core_datain   (core_datain),
    .core_key      (core_key),
    .core_finalout (core_finalout),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .busy          (busy)
`ifdef AES_STREAM_CNT_EN
    ,
    .blk_in_cnt    (blk_in_cnt),
    .blk_out_cnt   (blk_out_cnt)
`endif
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] t = x;
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gm(t, t);
      r = gm(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb(s[i]);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Unreset, unstallable core: sampled at the edge after issue, result
  // stable CORE_LAT edges later.
  logic [127:0] pipe [0:CORE_LAT];
  always @(posedge clk) begin
    for (int i = CORE_LAT; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= aes_enc(core_datain, core_key);
  end
  assign core_finalout = pipe[CORE_LAT];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on delivery.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (s_valid && s_ready) begin
        exp_q.push_back(drv_exp);
        acc_cnt++;
      end
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", m_data, 128'hx);
        end else begin
          chk("m_data", m_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] pts  [5];
  logic [127:0] keys [5];
  logic [31:0]  pfx  [5];
  int n, base, pbase, seen;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_key = '0; m_ready = 1'b0; drv_exp = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rst_s_ready", {127'd0, s_ready}, 128'd1);
    chk("rst_m_valid", {127'd0, m_valid}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_core_datain", core_datain, 128'd0);
    chk("rst_core_key", core_key, 128'd0);

    // Single block, latency and FIPS-197 C.1 result.
    m_ready = 1'b1;
    s_data  = 128'h00112233_44556677_8899aabb_ccddeeff;
    s_key   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    drv_exp = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("core_datain_load", core_datain, 128'h00112233_44556677_8899aabb_ccddeeff);
    chk("core_key_load", core_key, 128'h00010203_04050607_08090a0b_0c0d0e0f);
    n = 0;
    while (!m_valid && n < 40) begin step(); n++; end
    chk("single_latency", 128'(n), 128'd22);
    chk("single_m_data", m_data, 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a);
    step();
    chk("single_m_valid_low", {127'd0, m_valid}, 128'd0);

    // Five back-to-back blocks.
    pts[0] = 128'h3243f6a8_885a308d_313198a2_e0370734; keys[0] = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c; pfx[0] = 32'h3925841d;
    pts[1] = 128'h00112233_44556677_8899aabb_ccddeeff; keys[1] = 128'h00010203_04050607_08090a0b_0c0d0e0f; pfx[1] = 32'h69c4e0d8;
    pts[2] = 128'h0; keys[2] = 128'h0; pfx[2] = 32'h66e94bd4;
    pts[3] = 128'h0; keys[3] = 128'h1; pfx[3] = 32'h0545aad5;
    pts[4] = 128'h1; keys[4] = 128'h0; pfx[4] = 32'h58e2fcce;
    for (int k = 0; k < 5; k++) begin
      s_data = pts[k]; s_key = keys[k]; drv_exp = aes_enc(pts[k], keys[k]); s_valid = 1'b1;
      step();
    end
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 40) begin step(); n++; end
    chk("b2b_latency", 128'(n), 128'd18);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("b2b_m_valid_%0d", k), {127'd0, m_valid}, 128'd1);
      chk($sformatf("b2b_prefix_%0d", k), {96'd0, m_data[127:96]}, {96'd0, pfx[k]});
      step();
    end
    chk("b2b_m_valid_end", {127'd0, m_valid}, 128'd0);

    // Backpressure: exactly FIFO_DEPTH accepts, then lossless drain.
    m_ready = 1'b0;
    base = acc_cnt;
    s_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      s_data = 128'(i); s_key = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
      drv_exp = aes_enc(s_data, s_key);
      step();
    end
    s_valid = 1'b0;
    chk("bp_accepts", 128'(acc_cnt - base), 128'd32);
    chk("bp_s_ready_low", {127'd0, s_ready}, 128'd0);
    chk("bp_m_valid", {127'd0, m_valid}, 128'd1);
    pbase = pop_cnt;
    m_ready = 1'b1;
    #1;
    chk("bp_s_ready_before_pop", {127'd0, s_ready}, 128'd0);
    step();
    chk("bp_s_ready_after_pop", {127'd0, s_ready}, 128'd1);
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    chk("bp_pops", 128'(pop_cnt - pbase), 128'd32);
    chk("bp_queue_empty", 128'(exp_q.size()), 128'd0);

    // Reset with 5 queued and 10 in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_data = 128'(100 + i); s_key = 128'h77; drv_exp = aes_enc(s_data, s_key); s_valid = 1'b1;
      step();
    end
    s_valid = 1'b0;
    repeat (25) step();
    for (int i = 0; i < 10; i++) begin
      s_data = 128'(200 + i); s_key = 128'h99; drv_exp = aes_enc(s_data, s_key); s_valid = 1'b1;
      step();
    end
    s_valid = 1'b0;
    step();
    chk("pre_rst_busy", {127'd0, busy}, 128'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_m_valid", {127'd0, m_valid}, 128'd0);
    chk("mid_rst_s_ready", {127'd0, s_ready}, 128'd1);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_core_datain", core_datain, 128'd0);
    step();
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (m_valid) seen++;
    end
    chk("post_rst_no_output", 128'(seen), 128'd0);
    chk("post_rst_busy", {127'd0, busy}, 128'd0);

`ifdef AES_STREAM_CNT_EN
    // Counters after a fresh reset: 7 accepts, 4 pops.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_data = 128'(300 + i); s_key = 128'h5; drv_exp = aes_enc(s_data, s_key); s_valid = 1'b1;
      step();
    end
    s_valid = 1'b0;
    repeat (30) step();
    m_ready = 1'b1;
    repeat (4) step();
    m_ready = 1'b0;
    chk("blk_in_cnt", {96'd0, blk_in_cnt}, 128'd7);
    chk("blk_out_cnt", {96'd0, blk_out_cnt}, 128'd4);
    m_ready = 1'b1;
    n = 0;
    while (busy && n < 50) begin step(); n++; end
`endif

    chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
